ddr_cmd_issue: RTL
==================

Name: ddr_cmd_issue

Overview:
- Issue stage between the DDR command/write-data FIFOs (show-ahead, in the ui_clk domain) and the DDR3 memory interface IP user port.
- Pops one queued AXI-derived beat command and presents it to the IP with the cmd_en / wr_data_en handshake.
- Gates issue on calibration.
- Holds a read-credit counter so the read-return data FIFO can never overflow.
- Tracks outstanding reads and flags spurious read data.

Parameters:
- DATA_WIDTH, 256, data beat width.
- ADDR_WIDTH, 32, byte address width.
- STRB_WIDTH, DATA_WIDTH/8, byte strobe / mask width.
- RD_CREDITS, 16, read-return FIFO depth in beats; initial credit count.
- CNT_WIDTH, $clog2(RD_CREDITS+1), credit/outstanding counter width.

Ports:
- clk  in  1  ui_clk
- rst  in  1  synchronous active-high reset
- calib_done  in  1  IP init_calib_complete
- cmd_valid  in  1  command FIFO not empty
- cmd_rd  in  1  1=read, 0=write
- cmd_addr  in  ADDR_WIDTH  beat byte address
- cmd_strb  in  STRB_WIDTH  write byte enables
- cmd_data  in  DATA_WIDTH  write data
- cmd_pop  out  1  FIFO RdEn (combinational)
- ddr_cmd_en  out  1  IP cmd_en
- ddr_cmd  out  3  IP cmd: 3'b001 read, 3'b000 write
- ddr_addr  out  ADDR_WIDTH  beat-aligned address
- ddr_cmd_ready  in  1  IP cmd_ready
- ddr_wr_data_en  out  1  IP wr_data_en
- ddr_wr_data  out  DATA_WIDTH  IP wr_data
- ddr_wr_data_mask  out  STRB_WIDTH  IP wr_data_mask, 1=masked
- ddr_wr_data_end  out  1  IP wr_data_end
- ddr_wr_data_rdy  in  1  IP wr_data_rdy
- ddr_rd_data_valid  in  1  IP read beat returned
- rd_fifo_pop  in  1  consumer popped one beat from read-return FIFO
- rd_credits  out  CNT_WIDTH  free read-return slots
- rd_outstanding  out  CNT_WIDTH  reads issued, data not yet returned
- err_spurious  out  1  sticky: read data seen with rd_outstanding==0

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- States: IDLE, ISSUE.
- Registered command: cmd_rd, address, strb, data are captured on every cmd_pop.
- Accept condition: `acc = ISSUE & ddr_cmd_ready & (reg_rd | ddr_wr_data_rdy)`.
- can_take, all of:
  - calib_done
  - cmd_valid
  - (cmd_rd==0 or credits_next_avail>0), where credits_next_avail = rd_credits minus 1 if acc of a read this cycle.
- cmd_pop = can_take & (state==IDLE | acc).
- This allows back-to-back beats (1 per cycle while the IP stays ready).
- Transitions:
  - IDLE -> ISSUE on cmd_pop.
  - ISSUE -> ISSUE on acc & cmd_pop.
  - ISSUE -> IDLE on acc & ~cmd_pop.
  - ISSUE holds otherwise.
- Outputs in ISSUE:
  - ddr_cmd_en = acc; a single-cycle pulse per command, never asserted while ddr_cmd_ready=0.
  - ddr_wr_data_en = acc & ~reg_rd.
  - ddr_wr_data_end = ddr_wr_data_en.
- Outputs outside ISSUE: all enables are 0.
- ddr_addr = reg_addr with low $clog2(STRB_WIDTH) bits forced 0.
- ddr_wr_data_mask = reg_rd ? 0 : ~reg_strb.
- ddr_cmd = {2'b00, reg_rd}. Data/addr outputs are don't-care outside ISSUE but hold last value.
- Latency: cmd_valid rising in IDLE (calib_done=1, IP ready) -> cmd_pop same cycle -> ddr_cmd_en next cycle.
- Credits:
  - reset to RD_CREDITS.
  - -1 on read acc, +1 on rd_fifo_pop; both in same cycle -> unchanged.
  - Never exceeds RD_CREDITS; a pop at full saturates and sets err_spurious.
- rd_outstanding:
  - reset 0.
  - +1 on read acc, -1 on ddr_rd_data_valid; both -> unchanged.
  - ddr_rd_data_valid at 0 -> stays 0, err_spurious set.
- Writes never consume credits. A write at the FIFO head is not blocked by zero credits. Strict FIFO order: no reordering around a blocked read.
- calib_done low: no new pops; an in-flight ISSUE still completes on acc.
- rst mid-ISSUE: the command is dropped, no further cmd_en.
- Reset values: state IDLE, all enables 0, regs 0, rd_credits=RD_CREDITS, rd_outstanding=0, err_spurious=0.
- err_spurious is cleared only by rst.

Test Plan:
- calib_done=0, cmd_valid=1 for 20 cycles -> cmd_pop=0 and ddr_cmd_en=0 throughout; raise calib_done -> cmd_pop that cycle, ddr_cmd_en next.
- Write addr 0x1234_5678, strb=0xFFFF_0000, IP ready -> ddr_addr=0x1234_5660, ddr_cmd=0, ddr_wr_data_mask=0x0000_FFFF, wr_data_en=wr_data_end=1 with cmd_en for 1 cycle.
- Write with ddr_wr_data_rdy=0 for 5 cycles -> cmd_en held 0, outputs stable; rdy=1 -> one pulse, FIFO popped exactly once.
- 17 reads queued, RD_CREDITS=16, no rd_fifo_pop -> exactly 16 cmd_en pulses on consecutive cycles, rd_credits=0, 17th waits; one rd_fifo_pop -> 17th issues, rd_credits back to 0.
- Same-cycle read acc and rd_fifo_pop at credits=5 -> stays 5; ddr_rd_data_valid with rd_outstanding=0 -> err_spurious=1 sticky, counter stays 0.
- rst asserted in ISSUE with ddr_cmd_ready=0 -> next cycle state IDLE, no cmd_en, rd_credits=16, rd_outstanding=0.

Source files
------------

// File: rtl/ddr_cmd_issue.sv
// ddr_cmd_issue: issue stage between the show-ahead command/write-data FIFOs and the
// DDR3 memory interface IP user port (all in the ui_clk domain).
//
// Holds one popped beat command and presents it to the IP using the cmd_en /
// wr_data_en handshake. A new command may be popped in the same cycle the held one is
// accepted, so beats can issue back-to-back at one per cycle.
//
// Read issue is gated by a credit counter sized to the read-return FIFO, so that FIFO
// can never overflow. Reads in flight are counted, and read data arriving with nothing
// in flight raises a sticky error.
//
// Ports:
//   clk, rst                   ui_clk; synchronous active-high reset
//   calib_done                 IP init_calib_complete; no new pops while low
//   cmd_valid/rd/addr/strb/data  head of the command FIFO
//   cmd_pop                    FIFO RdEn (combinational)
//   ddr_cmd_en/cmd/addr        IP command port
//   ddr_cmd_ready              IP cmd_ready
//   ddr_wr_data_en/data/mask/end  IP write-data port (mask: 1 = byte masked)
//   ddr_wr_data_rdy            IP wr_data_rdy
//   ddr_rd_data_valid          IP read beat returned
//   rd_fifo_pop                consumer popped one beat from the read-return FIFO
//   rd_credits                 free read-return slots
//   rd_outstanding             reads issued whose data has not yet returned
//   err_spurious               sticky error: credit overflow or unexpected read data
module ddr_cmd_issue #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int RD_CREDITS = 16,
    parameter int CNT_WIDTH  = $clog2(RD_CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  calib_done,
    input  logic                  cmd_valid,
    input  logic                  cmd_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  cmd_pop,
    output logic                  ddr_cmd_en,
    output logic [2:0]            ddr_cmd,
    output logic [ADDR_WIDTH-1:0] ddr_addr,
    input  logic                  ddr_cmd_ready,
    output logic                  ddr_wr_data_en,
    output logic [DATA_WIDTH-1:0] ddr_wr_data,
    output logic [STRB_WIDTH-1:0] ddr_wr_data_mask,
    output logic                  ddr_wr_data_end,
    input  logic                  ddr_wr_data_rdy,
    input  logic                  ddr_rd_data_valid,
    input  logic                  rd_fifo_pop,
    output logic [CNT_WIDTH-1:0]  rd_credits,
    output logic [CNT_WIDTH-1:0]  rd_outstanding,
    output logic                  err_spurious
);

    // Address bits below one data beat.
    localparam int LSB = $clog2(STRB_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(RD_CREDITS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic {StIdle, StIssue} state_t;

    state_t                  state;
    logic                    reg_rd;
    logic [ADDR_WIDTH-1:0]   reg_addr;
    logic [STRB_WIDTH-1:0]   reg_strb;
    logic [DATA_WIDTH-1:0]   reg_data;
    logic [CNT_WIDTH-1:0]    credits;
    logic [CNT_WIDTH-1:0]    outstanding;
    logic                    err;

    logic                    in_issue;
    logic                    acc;
    logic                    rd_acc;
    logic                    can_take;
    logic [CNT_WIDTH-1:0]    credits_avail;

    assign in_issue = (state == StIssue);
    assign acc      = in_issue & ddr_cmd_ready & (reg_rd | ddr_wr_data_rdy);
    assign rd_acc   = acc & reg_rd;

    // Credit left once a read accepted this cycle is charged. A held read was
    // only popped with a credit in hand, so this never underflows.
    assign credits_avail = credits - (rd_acc ? CNT_ONE : '0);

    // Writes never wait on credits; a read at the head blocks everything behind it.
    assign can_take = calib_done & cmd_valid & (~cmd_rd | (credits_avail != '0));
    assign cmd_pop  = can_take & (~in_issue | acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            reg_rd      <= 1'b0;
            reg_addr    <= '0;
            reg_strb    <= '0;
            reg_data    <= '0;
            credits     <= CRED_MAX;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            unique case (state)
                StIdle:  if (cmd_pop) state <= StIssue;
                StIssue: if (acc && !cmd_pop) state <= StIdle;
                default: state <= StIdle;
            endcase

            if (cmd_pop) begin
                reg_rd   <= cmd_rd;
                reg_addr <= cmd_addr;
                reg_strb <= cmd_strb;
                reg_data <= cmd_data;
            end

            // Simultaneous charge and refund cancel out.
            if (rd_fifo_pop && !rd_acc) begin
                if (credits == CRED_MAX) err <= 1'b1;
                else                     credits <= credits + CNT_ONE;
            end else if (rd_acc && !rd_fifo_pop) begin
                credits <= credits - CNT_ONE;
            end

            if (ddr_rd_data_valid && !rd_acc) begin
                if (outstanding == '0) err <= 1'b1;
                else                   outstanding <= outstanding - CNT_ONE;
            end else if (rd_acc && !ddr_rd_data_valid) begin
                outstanding <= outstanding + CNT_ONE;
            end
        end
    end

    assign ddr_cmd_en       = acc;
    assign ddr_wr_data_en   = acc & ~reg_rd;
    assign ddr_wr_data_end  = acc & ~reg_rd;
    assign ddr_cmd          = {2'b00, reg_rd};
    assign ddr_addr         = {reg_addr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
    assign ddr_wr_data      = reg_data;
    assign ddr_wr_data_mask = reg_rd ? '0 : ~reg_strb;
    assign rd_credits       = credits;
    assign rd_outstanding   = outstanding;
    assign err_spurious     = err;

    // Sub-beat address bits are captured but never presented.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^reg_addr[LSB-1:0];

endmodule
